fft_frame_loader: RTL and testbench

Serial-to-parallel front end for the 8-point FFT stage. It accepts complex samples one per handshake, assembles a frame of 8, and presents the frame on 16 parallel buses. It then sequences the FFT's `write` and `start` controls and waits for the FFT to finish before accepting the next frame. It sits directly upstream of the FFT and drives its `in*` buses, `write` and `start`, and observes its `ready`.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_sample_buf.sv | 29 ++
 rtl/fft_frame_loader.sv | 141 ++++++++++++++
 tb/tb_fft_frame_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front end.
package fft_pkg;

    localparam int unsigned W           = 16;
    localparam int unsigned FFT_N       = 8;
    localparam int unsigned FFT_LAT_DEF = 2;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StLoad,
        StStart,
        StWait
    } loader_state_t;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_sample_buf.sv
// Frame buffer: one write port addressed by index, all entries readable in parallel.
module fft_sample_buf #(
    parameter int unsigned W  = 16,
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [W-1:0]  wr_real,
    input  logic [W-1:0]  wr_imag,
    output logic [W-1:0]  ent_real [N],
    output logic [W-1:0]  ent_imag [N]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                ent_real[i] <= '0;
                ent_imag[i] <= '0;
            end
        end else if (we) begin
            ent_real[widx] <= wr_real;
            ent_imag[widx] <= wr_imag;
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Collects 8 complex samples, presents them in parallel and sequences the FFT
// write/start strobes, then holds until the FFT reports ready.
module fft_frame_loader #(
    parameter int unsigned W       = fft_pkg::W,
    parameter int unsigned FFT_LAT = fft_pkg::FFT_LAT_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_real,
    input  logic [W-1:0]  s_imag,
    input  logic          s_last,
    output logic [W-1:0]  x0_real,
    output logic [W-1:0]  x0_imag,
    output logic [W-1:0]  x1_real,
    output logic [W-1:0]  x1_imag,
    output logic [W-1:0]  x2_real,
    output logic [W-1:0]  x2_imag,
    output logic [W-1:0]  x3_real,
    output logic [W-1:0]  x3_imag,
    output logic [W-1:0]  x4_real,
    output logic [W-1:0]  x4_imag,
    output logic [W-1:0]  x5_real,
    output logic [W-1:0]  x5_imag,
    output logic [W-1:0]  x6_real,
    output logic [W-1:0]  x6_imag,
    output logic [W-1:0]  x7_real,
    output logic [W-1:0]  x7_imag,
    output logic          fft_write,
    output logic          fft_start,
    input  logic          fft_ready,
    output logic          frame_done,
    output logic          frame_err,
    output logic [15:0]   frame_cnt
);

    import fft_pkg::*;

    localparam int unsigned IW = $clog2(FFT_N);
    localparam int unsigned LW = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(FFT_N - 1);

    loader_state_t state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [LW-1:0] lat_q;
    logic [15:0]   frame_cnt_q;
    logic          frame_done_q;
    logic          frame_err_q;

    logic          accept;
    logic          short_beat;
    logic          wait_exit;
    logic [W-1:0]  buf_real [FFT_N];
    logic [W-1:0]  buf_imag [FFT_N];

    assign accept     = (state_q == StFill) && s_valid;
    // s_last on the final beat is ignored; earlier it aborts the frame.
    assign short_beat = accept && s_last && (idx_q != IDX_LAST);
    assign wait_exit  = (state_q == StWait) && (lat_q == '0) && fft_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFill;
            StFill:  if (accept && idx_q == IDX_LAST) state_d = StLoad;
            StLoad:  state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (wait_exit) state_d = StFill;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            lat_q        <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= wait_exit;
            frame_err_q  <= short_beat;
            if (accept) begin
                idx_q <= short_beat ? '0 : idx_q + 1'b1;
            end else if (wait_exit) begin
                idx_q <= '0;
            end
            if (state_q == StStart) begin
                lat_q <= LW'(FFT_LAT - 1);
            end else if (state_q == StWait && lat_q != '0) begin
                lat_q <= lat_q - 1'b1;
            end
            if (wait_exit) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    fft_sample_buf #(
        .W  (W),
        .N  (FFT_N),
        .IW (IW)
    ) u_buf (
        .clk      (CLK),
        .rst_n    (RST_N),
        .we       (accept && !short_beat),
        .widx     (idx_q),
        .wr_real  (s_real),
        .wr_imag  (s_imag),
        .ent_real (buf_real),
        .ent_imag (buf_imag)
    );

    assign s_ready    = (state_q == StFill);
    assign fft_write  = (state_q == StLoad);
    assign fft_start  = (state_q == StStart);
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

    assign x0_real = buf_real[0];
    assign x0_imag = buf_imag[0];
    assign x1_real = buf_real[1];
    assign x1_imag = buf_imag[1];
    assign x2_real = buf_real[2];
    assign x2_imag = buf_imag[2];
    assign x3_real = buf_real[3];
    assign x3_imag = buf_imag[3];
    assign x4_real = buf_real[4];
    assign x4_imag = buf_imag[4];
    assign x5_real = buf_real[5];
    assign x5_imag = buf_imag[5];
    assign x6_real = buf_real[6];
    assign x6_imag = buf_imag[6];
    assign x7_real = buf_real[7];
    assign x7_imag = buf_imag[7];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: reset, framing, short frames, stalls, gaps.
module tb_fft_frame_loader;

    import fft_pkg::*;

    localparam int unsigned LAT = 2;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        s_valid, s_ready, s_last;
    logic [15:0] s_real, s_imag;
    logic [15:0] x0_real, x0_imag, x1_real, x1_imag, x2_real, x2_imag, x3_real, x3_imag;
    logic [15:0] x4_real, x4_imag, x5_real, x5_imag, x6_real, x6_imag, x7_real, x7_imag;
    logic        fft_write, fft_start, fft_ready, frame_done, frame_err;
    logic [15:0] frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    fft_frame_loader #(
        .W       (16),
        .FFT_LAT (LAT)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_real     (s_real),
        .s_imag     (s_imag),
        .s_last     (s_last),
        .x0_real    (x0_real),
        .x0_imag    (x0_imag),
        .x1_real    (x1_real),
        .x1_imag    (x1_imag),
        .x2_real    (x2_real),
        .x2_imag    (x2_imag),
        .x3_real    (x3_real),
        .x3_imag    (x3_imag),
        .x4_real    (x4_real),
        .x4_imag    (x4_imag),
        .x5_real    (x5_real),
        .x5_imag    (x5_imag),
        .x6_real    (x6_real),
        .x6_imag    (x6_imag),
        .x7_real    (x7_real),
        .x7_imag    (x7_imag),
        .fft_write  (fft_write),
        .fft_start  (fft_start),
        .fft_ready  (fft_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; s_valid = 1'b0; s_last = 1'b0; fft_ready = 1'b1;
        s_real = '0; s_imag = '0;
        repeat (2) tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; s_valid = 1'b1; s_last = 1'b0; fft_ready = 1'b1;
        s_real = 16'h1234; s_imag = 16'h5678;
        #1;
        repeat (3) begin
            tick();
            vectors++;
            if ({s_ready, fft_write, fft_start, frame_done, frame_err} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl: got %b expected 00000",
                         {s_ready, fft_write, fft_start, frame_done, frame_err});
            end
        end
        vectors++;
        if ({frame_cnt, x0_real, x7_imag} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", {frame_cnt, x0_real, x7_imag});
        end
        s_valid = 1'b0;
        RST_N   = 1'b1;
    endtask

    task automatic test_basic_frame();
        do_reset();
        s_valid = 1'b1; s_real = 16'd1; s_imag = 16'hFFFF;
        tick();
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_first_ready: got %b expected 1", s_ready);
        end
        for (int k = 0; k < 8; k++) begin
            s_real = 16'(k + 1);
            s_imag = 16'(-(k + 1));
            tick();
        end
        s_valid = 1'b0;
        vectors++;
        if ({fft_write, fft_start, s_ready} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_write: got %b expected 100", {fft_write, fft_start, s_ready});
        end
        tick();
        vectors++;
        if ({fft_write, fft_start} !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_start: got %b expected 01", {fft_write, fft_start});
        end
        vectors++;
        if (x3_real !== 16'd4 || x3_imag !== 16'hFFFC) begin
            miscompares++;
            $display("FAIL basic_x3: got %h/%h expected 0004/fffc", x3_real, x3_imag);
        end
        repeat (LAT) tick();
        vectors++;
        if (s_ready !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_wait: got %b%b expected 00", s_ready, frame_done);
        end
        tick();
        vectors++;
        if ({s_ready, frame_done} !== 2'b11 || frame_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL basic_done: got %b%b cnt %0d expected 11 cnt 1",
                     s_ready, frame_done, frame_cnt);
        end
        tick();
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got %b expected 0", frame_done);
        end
    endtask

    task automatic test_back_to_back();
        int low;
        logic both_seen;
        both_seen = 1'b0;
        do_reset();
        s_valid = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 8; b++) begin
                s_real = 16'(f * 8 + b);
                s_imag = 16'(100 + f * 8 + b);
                tick();
            end
            low = 0;
            while (s_ready !== 1'b1 && low < 20) begin
                if (fft_write === 1'b1 && fft_start === 1'b1) both_seen = 1'b1;
                low++;
                tick();
            end
            vectors++;
            if (low != int'(LAT) + 2) begin
                miscompares++;
                $display("FAIL b2b_gap_%0d: got %0d low cycles expected %0d", f, low, LAT + 2);
            end
        end
        s_valid = 1'b0;
        vectors++;
        if (frame_cnt !== 16'd3 || frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d/%b expected 3/1", frame_cnt, frame_done);
        end
        vectors++;
        if (x0_real !== 16'd16 || x7_imag !== 16'd123) begin
            miscompares++;
            $display("FAIL b2b_data: got %0d/%0d expected 16/123", x0_real, x7_imag);
        end
        vectors++;
        if (both_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_strobe_excl: got %b expected 0", both_seen);
        end
    endtask

    task automatic test_short_frame();
        logic write_seen;
        write_seen = 1'b0;
        do_reset();
        s_valid = 1'b1;
        tick();
        for (int b = 0; b < 5; b++) begin
            s_real = 16'(10 + b);
            s_imag = 16'(60 + b);
            s_last = (b == 4);
            tick();
            if (fft_write === 1'b1) write_seen = 1'b1;
        end
        s_last = 1'b0;
        vectors++;
        if ({frame_err, s_ready, write_seen} !== 3'b110) begin
            miscompares++;
            $display("FAIL short_err: got %b expected 110", {frame_err, s_ready, write_seen});
        end
        vectors++;
        if (x3_real !== 16'd13 || x4_real !== 16'd0) begin
            miscompares++;
            $display("FAIL short_drop: got %0d/%0d expected 13/0", x3_real, x4_real);
        end
        for (int b = 0; b < 8; b++) begin
            s_real = 16'(20 + b);
            s_imag = 16'(70 + b);
            tick();
            if (b == 0) begin
                vectors++;
                if (frame_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL short_err_pulse: got %b expected 0", frame_err);
                end
            end
        end
        s_valid = 1'b0;
        vectors++;
        if (fft_write !== 1'b1 || x0_real !== 16'd20 || x4_imag !== 16'd74) begin
            miscompares++;
            $display("FAIL short_next: got %b %0d %0d expected 1 20 74",
                     fft_write, x0_real, x4_imag);
        end
    endtask

    task automatic test_stalled_ready();
        do_reset();
        fft_ready = 1'b0;
        s_valid = 1'b1;
        tick();
        for (int b = 0; b < 8; b++) begin
            s_real = 16'(30 + b);
            s_imag = 16'(40 + b);
            tick();
        end
        s_valid = 1'b0;
        tick();
        vectors++;
        if (fft_start !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_start: got %b expected 1", fft_start);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if ({s_ready, fft_write, fft_start, frame_done} !== 4'b0 ||
                x0_real !== 16'd30 || x7_imag !== 16'd47) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got %b %0d %0d expected 0000 30 47", i,
                         {s_ready, fft_write, fft_start, frame_done}, x0_real, x7_imag);
            end
        end
        fft_ready = 1'b1;
        tick();
        vectors++;
        if ({s_ready, frame_done} !== 2'b11 || frame_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL stall_exit: got %b%b cnt %0d expected 11 cnt 1",
                     s_ready, frame_done, frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic strobe_seen;
        strobe_seen = 1'b0;
        do_reset();
        s_valid = 1'b1;
        tick();
        for (int b = 0; b < 5; b++) begin
            s_real = 16'(80 + b);
            tick();
        end
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({s_ready, fft_write, fft_start, frame_done, frame_err} !== 5'b0 ||
            x0_real !== 16'd0 || frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL midreset_fill: got %b %0d %0d expected 00000 0 0",
                     {s_ready, fft_write, fft_start, frame_done, frame_err}, x0_real, frame_cnt);
        end
        tick();
        RST_N = 1'b1;
        fft_ready = 1'b0;
        tick();
        for (int b = 0; b < 8; b++) begin
            s_real = 16'(90 + b);
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({s_ready, fft_write, fft_start, frame_done} !== 4'b0 ||
            x7_real !== 16'd0 || frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL midreset_wait: got %b %0d %0d expected 0000 0 0",
                     {s_ready, fft_write, fft_start, frame_done}, x7_real, frame_cnt);
        end
        tick();
        RST_N = 1'b1;
        fft_ready = 1'b1;
        repeat (6) begin
            tick();
            if (fft_write === 1'b1 || fft_start === 1'b1 || frame_done === 1'b1)
                strobe_seen = 1'b1;
        end
        vectors++;
        if (strobe_seen !== 1'b0 || frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL midreset_after: got %b cnt %0d expected 0 cnt 0",
                     strobe_seen, frame_cnt);
        end
    endtask

    task automatic test_gapped();
        int beats;
        int cyc;
        int last_cyc;
        do_reset();
        beats = 0;
        cyc = 0;
        last_cyc = -1;
        while (beats < 8 && cyc < 40) begin
            s_valid = cyc[0];
            s_real  = 16'(50 + beats);
            s_imag  = 16'(150 + beats);
            if (s_valid && s_ready) begin
                beats++;
                if (beats == 8) last_cyc = cyc;
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        vectors++;
        if (last_cyc != 15) begin
            miscompares++;
            $display("FAIL gap_beat7_cycle: got %0d expected 15", last_cyc);
        end
        vectors++;
        if ({fft_write, fft_start} !== 2'b10 || x5_real !== 16'd55 || x2_imag !== 16'd152) begin
            miscompares++;
            $display("FAIL gap_write: got %b %0d %0d expected 10 55 152",
                     {fft_write, fft_start}, x5_real, x2_imag);
        end
        tick();
        vectors++;
        if ({fft_write, fft_start} !== 2'b01) begin
            miscompares++;
            $display("FAIL gap_start: got %b expected 01", {fft_write, fft_start});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_short_frame();
        test_stalled_ready();
        test_reset_mid();
        test_gapped();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
